// File: rtl/logic_engine_defs.sv
// Shared definitions for the logic engine and its two-port arbiter:
// opcode values and the arbiter FSM state encoding.
package logic_engine_defs;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;
  localparam logic [1:0] OP_AND  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Round-robin pick: a lone valid requester wins, a tie goes to the
  // requester that was not served last.
  function automatic logic pick_winner(input logic v0, input logic v1,
                                       input logic last_grant);
    logic w;
    w = v1;
    if (v0 && v1) w = ~last_grant;
    return w;
  endfunction

endpackage

// File: rtl/logic_engine.sv
// Combinational bitwise logic unit: OR, NAND, NOR, AND selected by a 2-bit opcode.
module logic_engine
  import logic_engine_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_instruction,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    case (i_instruction)
      OP_OR:   out = i_a | i_b;
      OP_NAND: out = ~(i_a & i_b);
      OP_NOR:  out = ~(i_a | i_b);
      OP_AND:  out = i_a & i_b;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/logic_engine_arbiter.sv
// Two-requester round-robin front end for one shared logic_engine.
// Each operation takes IDLE (accept) -> EXEC (compute, register) -> RESP (hold until consumed).
module logic_engine_arbiter
  import logic_engine_defs::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [1:0]       i_req0_instr,
  output logic             o_rsp0_valid,
  output logic [WIDTH-1:0] o_rsp0_data,
  input  logic             i_rsp0_ready,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [1:0]       i_req1_instr,
  output logic             o_rsp1_valid,
  output logic [WIDTH-1:0] o_rsp1_data,
  input  logic             i_rsp1_ready,
  output logic             o_busy,
  output logic             o_grant,
  output logic [1:0]       o_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both high; a valid response stays asserted with
  // stable data until that edge, and request ready never depends on ready-less
  // feedback from the same requester.

  state_t           state_q;
  state_t           state_d;
  logic             last_grant_q;
  logic             grant_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       instr_q;
  logic [WIDTH-1:0] engine_out;

  logic             any_valid;
  logic             winner;
  logic             accept;
  logic             rsp_take;
  logic             ready0;
  logic             ready1;

  assign any_valid = i_req0_valid | i_req1_valid;
  assign winner    = pick_winner(i_req0_valid, i_req1_valid, last_grant_q);
  assign rsp_take  = grant_q ? i_rsp1_ready : i_rsp0_ready;
  assign accept    = (state_q == ST_IDLE) && any_valid;

  logic_engine #(
    .WIDTH(WIDTH)
  ) u_engine (
    .i_a          (a_q),
    .i_b          (b_q),
    .i_instruction(instr_q),
    .out          (engine_out)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_EXEC;
          ready0  = ~winner;
          ready1  = winner;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_take) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are captured from the winner only, so later request changes
  // cannot disturb the operation already in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q          <= '0;
      b_q          <= '0;
      instr_q      <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (accept) begin
        a_q     <= winner ? i_req1_a     : i_req0_a;
        b_q     <= winner ? i_req1_b     : i_req0_b;
        instr_q <= winner ? i_req1_instr : i_req0_instr;
        grant_q <= winner;
      end
      if ((state_q == ST_RESP) && rsp_take) begin
        last_grant_q <= grant_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp0_valid <= 1'b0;
      o_rsp0_data  <= '0;
      o_rsp1_valid <= 1'b0;
      o_rsp1_data  <= '0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          if (grant_q) begin
            o_rsp1_data  <= engine_out;
            o_rsp1_valid <= 1'b1;
          end else begin
            o_rsp0_data  <= engine_out;
            o_rsp0_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_take) begin
            o_rsp0_valid <= 1'b0;
            o_rsp1_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req0_ready = ready0;
  assign o_req1_ready = ready1;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_grant      = grant_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_logic_engine_arbiter.sv
// Directed bench for logic_engine_arbiter: a vector table of single operations
// plus sequences for back-to-back ties, backpressure and mid-operation reset.
module tb_logic_engine_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_instr, req1_instr;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_ready, rsp1_ready;
  logic       busy;
  logic       grant;
  logic [1:0] state;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [1:0] op0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [1:0] op1;
    logic       exp_g;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] exp_q[$];
  logic [0:0] exp_gq[$];

  logic_engine_arbiter #(.WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req0_valid(req0_valid),
    .o_req0_ready(req0_ready),
    .i_req0_a    (req0_a),
    .i_req0_b    (req0_b),
    .i_req0_instr(req0_instr),
    .o_rsp0_valid(rsp0_valid),
    .o_rsp0_data (rsp0_data),
    .i_rsp0_ready(rsp0_ready),
    .i_req1_valid(req1_valid),
    .o_req1_ready(req1_ready),
    .i_req1_a    (req1_a),
    .i_req1_b    (req1_b),
    .i_req1_instr(req1_instr),
    .o_rsp1_valid(rsp1_valid),
    .o_rsp1_data (rsp1_data),
    .i_rsp1_ready(rsp1_ready),
    .o_busy      (busy),
    .o_grant     (grant),
    .o_state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [1:0] op0, input logic v1, input logic [7:0] a1,
                         input logic [7:0] b1, input logic [1:0] op1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_instr = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_instr = op1;
  endtask

  task automatic scramble_idle();
    set_req(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)), 1'b0, 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
  task automatic apply_vec(input vec_t v, input string tag);
    set_req(v.v0, v.a0, v.b0, v.op0, v.v1, v.a1, v.b1, v.op1);
    #1;
    check({tag, " req0_ready"}, 32'(req0_ready), 32'(!v.exp_g));
    check({tag, " req1_ready"}, 32'(req1_ready), 32'(v.exp_g));
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    scramble_idle();
    #1;
    check({tag, " exec busy"}, 32'(busy), 32'd1);
    check({tag, " exec grant"}, 32'(grant), 32'(v.exp_g));
    check({tag, " exec no rsp"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
    @(negedge clk);
    check({tag, " rsp0_valid"}, 32'(rsp0_valid), 32'(!v.exp_g));
    check({tag, " rsp1_valid"}, 32'(rsp1_valid), 32'(v.exp_g));
    check({tag, " rsp data"}, 32'(v.exp_g ? rsp1_data : rsp0_data), 32'(v.exp_d));
    @(negedge clk);
    check({tag, " rsp cleared"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check({tag, " back idle"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int last_acc;
    int n_rsp;
    vec_t tie;

    tests_run = 0;
    tests_failed = 0;
    // opcodes: 00 OR, 01 NAND, 10 NOR, 11 AND
    vecs[0] = '{1'b1, 1'b0, 8'haa, 8'h55, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'hff};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 8'h12, 8'h23, 2'b01, 1'b1, 8'hfd};
    vecs[2] = '{1'b1, 1'b0, 8'hff, 8'h01, 2'b11, 8'h00, 8'h00, 2'b00, 1'b0, 8'h01};
    vecs[3] = '{1'b1, 1'b1, 8'h80, 8'hc4, 2'b10, 8'hff, 8'hff, 2'b01, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'h80, 8'hc4, 2'b10, 8'hff, 8'hff, 2'b01, 1'b0, 8'h3b};
    vecs[5] = '{1'b1, 1'b1, 8'h0f, 8'hf0, 2'b00, 8'h3c, 8'h0f, 2'b11, 1'b1, 8'h0c};
    vecs[6] = '{1'b1, 1'b1, 8'hf0, 8'h0f, 2'b01, 8'h11, 8'h22, 2'b00, 1'b0, 8'hff};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 8'h0f, 8'h30, 2'b10, 1'b1, 8'hc0};

    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset grant", 32'(grant), 32'd0);
    check("reset rsp valids", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("reset rsp data", 32'({rsp0_data, rsp1_data}), 32'd0);
    check("reset req readies", 32'({req0_ready, req1_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters valid from reset, response ready high: strict alternation.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      exp_gq.push_back(1'b0); exp_q.push_back(8'h3b);
      exp_gq.push_back(1'b1); exp_q.push_back(8'h00);
    end
    set_req(1'b1, 8'h80, 8'hc4, 2'b10, 1'b1, 8'hff, 8'hff, 2'b01);
    #1;
    last_acc = -1;
    n_rsp = 0;
    for (int c = 0; c < 40 && n_rsp < 6; c++) begin
      check("ready exclusive", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_ready || req1_ready) begin
        if (exp_gq.size() > 0) check("alt grant", 32'(req1_ready), 32'(exp_gq.pop_front()));
        else check("alt extra accept", 32'd1, 32'd0);
        if (last_acc >= 0) check("accept spacing", 32'(c - last_acc), 32'd3);
        last_acc = c;
      end
      if (rsp0_valid || rsp1_valid) begin
        check("one rsp channel", 32'(rsp0_valid & rsp1_valid), 32'd0);
        if (exp_q.size() > 0)
          check("alt rsp data", 32'(rsp1_valid ? rsp1_data : rsp0_data), 32'(exp_q.pop_front()));
        check("rsp channel matches grant", 32'(rsp1_valid), 32'(grant));
        n_rsp++;
      end
      if (n_rsp == 6) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("alt response count", 32'(n_rsp), 32'd6);
    check("alt grants left", 32'(exp_gq.size()), 32'd0);

    // Backpressure: req0 wins the tie (req1 served last) and holds its response.
    rsp0_ready = 1'b0;
    set_req(1'b1, 8'h00, 8'h00, 2'b10, 1'b1, 8'h01, 8'h02, 2'b00);
    #1;
    check("bp req0_ready", 32'(req0_ready), 32'd1);
    check("bp req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req0_a = 8'h5a;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp rsp0 held", 32'(rsp0_valid), 32'd1);
      check("bp rsp0 data", 32'(rsp0_data), 32'hff);
      check("bp busy", 32'(busy), 32'd1);
      check("bp req1 blocked", 32'(req1_ready), 32'd0);
      check("bp rsp1 quiet", 32'(rsp1_valid), 32'd0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp rsp0 consumed", 32'(rsp0_valid), 32'd0);
    check("bp req1 now ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check("bp req1 grant", 32'(grant), 32'd1);
    @(negedge clk);
    check("bp rsp1 valid", 32'(rsp1_valid), 32'd1);
    check("bp rsp1 data", 32'(rsp1_data), 32'h03);
    @(negedge clk);

    // Reset while executing: nothing completes, outputs clear at once.
    set_req(1'b1, 8'haa, 8'h55, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("mid exec busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst grant", 32'(grant), 32'd0);
    check("mid rst rsp valids", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("mid rst rsp data", 32'({rsp0_data, rsp1_data}), 32'd0);
    check("mid rst state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post rst no rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      check("post rst idle", 32'(busy), 32'd0);
    end
    tie = '{1'b1, 1'b1, 8'hf0, 8'h3c, 2'b11, 8'h01, 8'h02, 2'b00, 1'b0, 8'h30};
    apply_vec(tie, "post rst tie");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
